lift_floor_ctrl: RTL
====================

Name: lift_floor_ctrl

Overview:
- Consumes the one-cycle call pulses produced by the per-button pulse generators. Each pulse latches a floor request.
- Runs the car with a SCAN (elevator) policy: continue in the current direction while requests lie ahead, otherwise reverse.
- Times floor-to-floor travel and door dwell with internal counters.
- Drives motor and door outputs for the top-level lift controller.

Parameters:
- N_FLOORS, 4, number of floors (2..16); floors numbered 0..N_FLOORS-1.
- TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
- DOOR_CYCLES, 3, clock cycles the door stays open (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- req_pulse  in  N_FLOORS  one-cycle call pulses, bit i = floor i; several bits may be high at once.
- cur_floor  out  $clog2(N_FLOORS)  current car floor, registered.
- pending  out  N_FLOORS  latched outstanding requests.
- motor_up  out  1  high while in MOVE_UP.
- motor_dn  out  1  high while in MOVE_DN.
- door_open  out  1  high while in DOOR.
- dir_up  out  1  direction preference, 1 = up.

Behaviour:
- Reset values: state IDLE, cur_floor 0, pending 0, all timers 0, motor_up/motor_dn/door_open 0, dir_up 1. All outputs are registered.
- Request latch: pending[i] sets on the edge after req_pulse[i]=1.
  - Exception: the pulse targets cur_floor while the state is IDLE or DOOR; the bit is never set.
  - A duplicate pulse for an already-pending floor has no effect.
  - If set and clear hit the same bit on the same edge, clear wins.
- "above" = any pending bit with index > cur_floor; "below" = any pending bit with index < cur_floor.
- IDLE, priority order:
  - Pulse for cur_floor → DOOR next edge.
  - above && (dir_up || !below) → MOVE_UP, dir_up=1.
  - below → MOVE_DN, dir_up=0.
  - Otherwise stay in IDLE.
  - Decisions use the registered pending only; a pulse arriving in IDLE affects movement one cycle later.
- MOVE_UP / MOVE_DN:
  - travel counter is 0 on entry and increments each cycle.
  - When the counter reaches TRAVEL_CYCLES-1, the next edge moves cur_floor ±1 and resets the counter.
  - On that same edge: if pending[new floor] is set, clear it and go to DOOR; otherwise remain in MOVE.
  - Pulses for floors passed mid-travel are latched normally and served on a later sweep.
- DOOR:
  - door counter is 0 on entry; door_open=1.
  - After DOOR_CYCLES cycles → IDLE.
  - A pulse for cur_floor during DOOR resets the door counter to 0, extending the dwell.
- Arrival latency: from entering MOVE, exactly d*TRAVEL_CYCLES cycles to reach distance d.
- Boundaries: cur_floor never leaves 0..N_FLOORS-1. MOVE is only entered with a target ahead, so no wrap-around is possible.
- Reset mid-travel: state returns to IDLE, floor 0, pending cleared; no position recovery.

Optional Feature:
- Macro: LIFT_ESTOP_EN.
- Defined:
  - Adds input port estop (1 bit, level-sensitive).
  - estop=1 from any state forces HALT on the next edge: motors 0, door_open 0, pending cleared, timers cleared, cur_floor held, req_pulse ignored.
  - On estop=0, HALT → IDLE on the next edge. Partial travel is abandoned and the car is treated as at cur_floor.
  - estop has priority over every other transition except rst_n.
- Undefined: no estop port, no HALT state; behaviour exactly as above.

Test Plan (N_FLOORS=4, TRAVEL_CYCLES=4, DOOR_CYCLES=3):
1. Hold rst_n=0 for 2 cycles → cur_floor=0, pending=0000, motor_up=motor_dn=door_open=0, dir_up=1.
2. At floor 0 in IDLE, pulse req_pulse=0100 → pending=0100 next edge; MOVE_UP on the following edge; cur_floor=1 after 4 cycles, =2 after 8; pending=0000 and door_open=1 for 3 cycles; then IDLE.
3. At floor 0 in IDLE, pulse req_pulse=0001 → pending stays 0000; door_open=1 on the next edge for 3 cycles; no motor activity.
4. From floor 1, pending=1000 and moving up, pulse 0101 → stops at 2 (clears bit 2), continues to 3, then MOVE_DN to 0 with dir_up=0; pending ends 0000.
5. In DOOR at floor 2, pulse 0100 in the 2nd door cycle → door dwell restarts, total open 5 cycles; pending bit 2 never set. Pulse 0010 twice while pending → single latch.
6. LIFT_ESTOP_EN defined: assert estop mid-travel 1→2 with pending=1100 → next edge HALT, motors 0, pending 0000, cur_floor=1. Release → IDLE; new pulse 0100 travels the full 4 cycles.

Source files
------------

// File: rtl/lift_floor_ctrl.sv
// rtl/lift_floor_ctrl.sv - SCAN-policy lift floor controller with travel and door timers
// Optional emergency stop: define LIFT_ESTOP_EN to add the estop input and HALT state.
module lift_floor_ctrl #(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_FLOORS-1:0]         req_pulse,
`ifdef LIFT_ESTOP_EN
  input  logic                        estop,
`endif
  output logic [$clog2(N_FLOORS)-1:0] cur_floor,
  output logic [N_FLOORS-1:0]         pending,
  output logic                        motor_up,
  output logic                        motor_dn,
  output logic                        door_open,
  output logic                        dir_up
);

  localparam int FW = $clog2(N_FLOORS);
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

`ifdef LIFT_ESTOP_EN
  typedef enum logic [2:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR} state_t;
`endif

  state_t              state_q, state_d;
  logic [FW-1:0]       cur_floor_q, cur_floor_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]       travel_q, travel_d;
  logic [DW-1:0]       door_q, door_d;
  logic                dir_up_q, dir_up_d;
  logic                motor_up_q, motor_up_d;
  logic                motor_dn_q, motor_dn_d;
  logic                door_open_q, door_open_d;

  logic [N_FLOORS-1:0] cur_onehot, next_onehot, above_mask, below_mask;
  logic [N_FLOORS-1:0] set_mask, clr_mask;
  logic [FW-1:0]       next_floor;
  logic                above, below, hit_cur, arrive_hit;

  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above_mask[i] = (FW'(i) > cur_floor_q);
      below_mask[i] = (FW'(i) < cur_floor_q);
    end
  end

  // next_floor is only meaningful in a MOVE state, where it is always in range
  assign next_floor  = (state_q == S_MOVE_UP) ? cur_floor_q + FW'(1) : cur_floor_q - FW'(1);
  assign cur_onehot  = N_FLOORS'(1) << cur_floor_q;
  assign next_onehot = N_FLOORS'(1) << next_floor;
  assign above       = |(pending_q & above_mask);
  assign below       = |(pending_q & below_mask);
  assign hit_cur     = |(req_pulse & cur_onehot);
  assign arrive_hit  = |(pending_q & next_onehot);

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    travel_d    = travel_q;
    door_d      = door_q;
    dir_up_d    = dir_up_q;
    clr_mask    = '0;
    set_mask    = req_pulse;

    // A call for the floor the car is standing at is served by the door, never latched
    if (state_q == S_IDLE || state_q == S_DOOR) begin
      set_mask = req_pulse & ~cur_onehot;
    end
`ifdef LIFT_ESTOP_EN
    if (state_q == S_HALT) begin
      set_mask = '0;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (hit_cur) begin
          state_d = S_DOOR;
          door_d  = '0;
        end else if (above && (dir_up_q || !below)) begin
          state_d  = S_MOVE_UP;
          dir_up_d = 1'b1;
          travel_d = '0;
        end else if (below) begin
          state_d  = S_MOVE_DN;
          dir_up_d = 1'b0;
          travel_d = '0;
        end
      end
      S_MOVE_UP, S_MOVE_DN: begin
        if (travel_q == TRAVEL_LAST) begin
          travel_d    = '0;
          cur_floor_d = next_floor;
          if (arrive_hit) begin
            clr_mask = next_onehot;
            state_d  = S_DOOR;
            door_d   = '0;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      S_DOOR: begin
        if (hit_cur) begin
          door_d = '0;
        end else if (door_q == DOOR_LAST) begin
          state_d = S_IDLE;
          door_d  = '0;
        end else begin
          door_d = door_q + DW'(1);
        end
      end
`ifdef LIFT_ESTOP_EN
      S_HALT: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pending_d = (pending_q | set_mask) & ~clr_mask;

`ifdef LIFT_ESTOP_EN
    // Emergency stop overrides everything; partial travel is simply forgotten
    if (estop) begin
      state_d     = S_HALT;
      pending_d   = '0;
      travel_d    = '0;
      door_d      = '0;
      cur_floor_d = cur_floor_q;
      dir_up_d    = dir_up_q;
    end
`endif

    motor_up_d  = (state_d == S_MOVE_UP);
    motor_dn_d  = (state_d == S_MOVE_DN);
    door_open_d = (state_d == S_DOOR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_floor_q <= '0;
      pending_q   <= '0;
      travel_q    <= '0;
      door_q      <= '0;
      dir_up_q    <= 1'b1;
      motor_up_q  <= 1'b0;
      motor_dn_q  <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      pending_q   <= pending_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      dir_up_q    <= dir_up_d;
      motor_up_q  <= motor_up_d;
      motor_dn_q  <= motor_dn_d;
      door_open_q <= door_open_d;
    end
  end

  assign cur_floor = cur_floor_q;
  assign pending   = pending_q;
  assign motor_up  = motor_up_q;
  assign motor_dn  = motor_dn_q;
  assign door_open = door_open_q;
  assign dir_up    = dir_up_q;

endmodule
